// File: rtl/pipe_hazard_sched_if.sv
// Bundle of ID-stage instruction fields, pipeline control outputs and
// performance counters that the issue scheduler exchanges with the core.
interface pipe_hazard_sched_if #(
  parameter int CNT_W = 32
);
  logic             in_start;
  logic             in_halt;
  logic [4:0]       in_rs_addr;
  logic [4:0]       in_rt_addr;
  logic             in_rs_rena;
  logic             in_rt_rena;
  logic [4:0]       in_rd_addr;
  logic             in_rd_wena;
  logic             in_branch;
  logic             out_stall;
  logic             out_pc_wena;
  logic             out_if_id_wena;
  logic             out_if_flush;
  logic             out_id_bubble;
  logic             out_busy;
  logic             out_done;
  logic [1:0]       out_state;
  logic [CNT_W-1:0] out_stall_count;
  logic [CNT_W-1:0] out_flush_count;
  logic [CNT_W-1:0] out_issue_count;

  modport master (
    output in_start, in_halt, in_rs_addr, in_rt_addr, in_rs_rena, in_rt_rena,
           in_rd_addr, in_rd_wena, in_branch,
    input  out_stall, out_pc_wena, out_if_id_wena, out_if_flush, out_id_bubble,
           out_busy, out_done, out_state, out_stall_count, out_flush_count,
           out_issue_count
  );

  modport slave (
    input  in_start, in_halt, in_rs_addr, in_rt_addr, in_rs_rena, in_rt_rena,
           in_rd_addr, in_rd_wena, in_branch,
    output out_stall, out_pc_wena, out_if_id_wena, out_if_flush, out_id_bubble,
           out_busy, out_done, out_state, out_stall_count, out_flush_count,
           out_issue_count
  );
endinterface

// File: rtl/pipe_hazard_sched.sv
// ID-stage issue scheduler: per-register countdown scoreboard for RAW hazards,
// branch flush control, run/drain/done FSM and saturating perf counters.
module pipe_hazard_sched #(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 32
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  pipe_hazard_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] LAT = 2'(WB_LAT);

  state_t           state;
  state_t           state_next;
  logic [1:0]       sb [32];
  logic             hazard;
  logic             issue;
  logic             sb_load;
  logic             busy;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] issue_count;

  // r0 is hardwired to zero, so it can never be a pending producer.
  always_comb begin
    hazard = 1'b0;
    if (bus.in_rs_rena && bus.in_rs_addr != 5'd0 && sb[bus.in_rs_addr] != 2'd0)
      hazard = 1'b1;
    if (bus.in_rt_rena && bus.in_rt_addr != 5'd0 && sb[bus.in_rt_addr] != 2'd0)
      hazard = 1'b1;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < 32; i++)
      busy = busy | (sb[i] != 2'd0);
  end

  assign issue   = (state == RUN) && !bus.in_halt && !hazard;
  assign sb_load = issue && bus.in_rd_wena && (bus.in_rd_addr != 5'd0);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Drain completes on the pre-decrement scoreboard, one edge after the last
  // pending write has counted down to zero.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_start) state_next = RUN;
      RUN:     if (bus.in_halt)  state_next = DRAIN;
      DRAIN:   if (!busy)        state_next = DONE;
      DONE:    if (bus.in_start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // A fresh load wins over the decrement, so a WAW reissue restarts the count.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < 32; i++)
        sb[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (sb_load && bus.in_rd_addr == 5'(i))
          sb[i] <= LAT;
        else if (sb[i] != 2'd0)
          sb[i] <= sb[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      stall_count <= '0;
      flush_count <= '0;
      issue_count <= '0;
    end else begin
      if (state == RUN && !bus.in_halt && hazard && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (issue && bus.in_branch && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
      if (issue && issue_count != '1)
        issue_count <= issue_count + CNT_W'(1);
    end
  end

  // A branch seen while stalled has stale operands; only the issuing copy flushes.
  assign bus.out_stall       = !issue;
  assign bus.out_pc_wena     = issue;
  assign bus.out_if_id_wena  = issue;
  assign bus.out_id_bubble   = !issue;
  assign bus.out_if_flush    = issue && bus.in_branch;
  assign bus.out_busy        = busy;
  assign bus.out_done        = (state == DONE);
  assign bus.out_state       = state;
  assign bus.out_stall_count = stall_count;
  assign bus.out_flush_count = flush_count;
  assign bus.out_issue_count = issue_count;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Directed bench for pipe_hazard_sched: a vector table on a WB_LAT=3 instance,
// plus hand sequences for reset-in-drain, WB_LAT=1 and counter saturation.
module tb_pipe_hazard_sched;

  logic in_clk;
  logic in_rst;

  pipe_hazard_sched_if #(.CNT_W(32)) bus_a ();
  pipe_hazard_sched_if #(.CNT_W(4))  bus_b ();

  pipe_hazard_sched #(.WB_LAT(3), .CNT_W(32)) dut_a (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus_a)
  );

  pipe_hazard_sched #(.WB_LAT(1), .CNT_W(4)) dut_b (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus_b)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic       start;
    logic       halt;
    logic [4:0] rs;
    logic       rs_en;
    logic [4:0] rt;
    logic       rt_en;
    logic [4:0] rd;
    logic       rd_en;
    logic       branch;
    logic       e_stall;
    logic       e_flush;
    logic       e_busy;
    logic [1:0] e_state;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   passed;

  function automatic vec_t mk(logic start, logic halt, logic [4:0] rs, logic rs_en,
                              logic [4:0] rt, logic rt_en, logic [4:0] rd, logic rd_en,
                              logic branch, logic e_stall, logic e_flush, logic e_busy,
                              logic [1:0] e_state);
    vec_t v;
    v.start = start;  v.halt = halt;   v.rs = rs;   v.rs_en = rs_en;
    v.rt = rt;        v.rt_en = rt_en; v.rd = rd;   v.rd_en = rd_en;
    v.branch = branch;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_busy = e_busy; v.e_state = e_state;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus_a.in_start   = v.start;
    bus_a.in_halt    = v.halt;
    bus_a.in_rs_addr = v.rs;
    bus_a.in_rs_rena = v.rs_en;
    bus_a.in_rt_addr = v.rt;
    bus_a.in_rt_rena = v.rt_en;
    bus_a.in_rd_addr = v.rd;
    bus_a.in_rd_wena = v.rd_en;
    bus_a.in_branch  = v.branch;
  endtask

  task automatic drive_b(input logic start, input logic halt, input logic [4:0] rs,
                         input logic rs_en, input logic [4:0] rd, input logic rd_en);
    bus_b.in_start   = start;
    bus_b.in_halt    = halt;
    bus_b.in_rs_addr = rs;
    bus_b.in_rs_rena = rs_en;
    bus_b.in_rt_addr = 5'd0;
    bus_b.in_rt_rena = 1'b0;
    bus_b.in_rd_addr = rd;
    bus_b.in_rd_wena = rd_en;
    bus_b.in_branch  = 1'b0;
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic check_row(input string tag, input vec_t v);
    check_output({tag, " stall"},     bus_a.out_stall,      v.e_stall);
    check_output({tag, " pc_wena"},   bus_a.out_pc_wena,    !v.e_stall);
    check_output({tag, " bubble"},    bus_a.out_id_bubble,  v.e_stall);
    check_output({tag, " if_flush"},  bus_a.out_if_flush,   v.e_flush);
    check_output({tag, " busy"},      bus_a.out_busy,       v.e_busy);
    check_output({tag, " state"},     bus_a.out_state,      v.e_state);
    check_output({tag, " done"},      bus_a.out_done,       v.e_state == 2'd3);
  endtask

  initial begin
    vec_t idle_v;
    int   exp_iss;
    total  = 0;
    passed = 0;
    idle_v = mk(0,0, 0,0, 0,0, 0,0, 0, 1,0,0,0);
    in_rst = 1'b1;
    apply_stimulus(idle_v);
    drive_b(0, 0, 5'd0, 0, 5'd0, 0);

    // Independent stream, RAW stall, r0 writes, branches, halt/drain, restart.
    vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,  1,0,0,0));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(0,0, 0,0, 0,0, 5'(k),1, 0,  0,0,(k != 1),1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 8,1, 0,  0,0,1,1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0, 8,1, 0,0, 0,0, 0,  1,0,1,1));
    vecs.push_back(mk(0,0, 8,1, 0,0, 0,0, 0,  0,0,0,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,1, 0,  0,0,0,1));
    vecs.push_back(mk(0,0, 0,1, 0,1, 0,0, 0,  0,0,0,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,  0,1,0,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 10,1, 0, 0,0,0,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 11,1, 0, 0,0,1,1));
    vecs.push_back(mk(0,0, 0,0, 10,1, 0,0, 1, 1,0,1,1));
    vecs.push_back(mk(0,0, 0,0, 10,1, 0,0, 1, 1,0,1,1));
    vecs.push_back(mk(0,0, 0,0, 10,1, 0,0, 1, 0,1,1,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 9,1, 0,  0,0,0,1));
    vecs.push_back(mk(0,1, 0,0, 0,0, 12,1, 0, 1,0,1,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,  1,0,1,2));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,  1,0,1,2));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,  1,0,0,2));
    vecs.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,  1,0,0,3));
    vecs.push_back(mk(1,1, 0,0, 0,0, 0,0, 0,  1,0,0,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,  1,0,0,2));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,  1,0,0,3));

    tick();
    tick();
    in_rst = 1'b0;
    #1;
    check_row("reset", idle_v);
    check_output("reset if_id_wena", bus_a.out_if_id_wena, 0);
    check_output("reset stall_count", bus_a.out_stall_count, 0);
    check_output("reset issue_count", bus_a.out_issue_count, 0);
    check_output("reset flush_count", bus_a.out_flush_count, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      #2;
      check_row($sformatf("row%0d", i), vecs[i]);
      tick();
      if (i == 5) begin
        check_output("stream issue_count", bus_a.out_issue_count, 5);
        check_output("stream stall_count", bus_a.out_stall_count, 0);
      end
      if (i == 10) begin
        check_output("raw stall_count", bus_a.out_stall_count, 3);
        check_output("raw issue_count", bus_a.out_issue_count, 7);
      end
      if (i == 13) check_output("branch flush_count", bus_a.out_flush_count, 1);
      if (i == 18) begin
        check_output("held branch flush_count", bus_a.out_flush_count, 2);
        check_output("held branch stall_count", bus_a.out_stall_count, 5);
        check_output("held branch issue_count", bus_a.out_issue_count, 13);
      end
    end
    check_output("final stall_count", bus_a.out_stall_count, 5);
    check_output("final flush_count", bus_a.out_flush_count, 2);
    check_output("final issue_count", bus_a.out_issue_count, 14);

    // Reset while r9 is still pending in DRAIN must discard everything.
    apply_stimulus(mk(1,0, 0,0, 0,0, 0,0, 0, 1,0,0,3));
    tick();
    apply_stimulus(mk(0,0, 0,0, 0,0, 9,1, 0, 0,0,0,1));
    tick();
    apply_stimulus(mk(0,1, 0,0, 0,0, 0,0, 0, 1,0,1,1));
    tick();
    apply_stimulus(idle_v);
    #1;
    check_output("pre-reset state", bus_a.out_state, 2);
    check_output("pre-reset busy", bus_a.out_busy, 1);
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    check_row("mid reset", idle_v);
    check_output("mid reset stall_count", bus_a.out_stall_count, 0);
    check_output("mid reset flush_count", bus_a.out_flush_count, 0);
    check_output("mid reset issue_count", bus_a.out_issue_count, 0);
    apply_stimulus(mk(1,0, 0,0, 0,0, 0,0, 0, 1,0,0,0));
    tick();
    apply_stimulus(mk(0,0, 9,1, 0,0, 0,0, 0, 0,0,0,1));
    #1;
    check_output("r9 cleared stall", bus_a.out_stall, 0);
    tick();
    apply_stimulus(idle_v);

    // WB_LAT=1 instance: one stall cycle, then saturation of a 4-bit counter.
    drive_b(1, 0, 5'd0, 0, 5'd0, 0);
    tick();
    drive_b(0, 0, 5'd0, 0, 5'd8, 1);
    #1;
    check_output("lat1 producer stall", bus_b.out_stall, 0);
    tick();
    drive_b(0, 0, 5'd8, 1, 5'd0, 0);
    #1;
    check_output("lat1 consumer stall", bus_b.out_stall, 1);
    tick();
    #1;
    check_output("lat1 consumer issue", bus_b.out_stall, 0);
    tick();
    check_output("lat1 stall_count", bus_b.out_stall_count, 1);
    check_output("lat1 issue_count", bus_b.out_issue_count, 2);
    drive_b(0, 0, 5'd0, 0, 5'd3, 1);
    exp_iss = 2;
    for (int n = 0; n < 16; n++) begin
      tick();
      exp_iss = (exp_iss < 15) ? exp_iss + 1 : 15;
      if (n >= 11)
        check_output($sformatf("sat issue_count n%0d", n), bus_b.out_issue_count, exp_iss);
    end
    drive_b(0, 0, 5'd0, 0, 5'd0, 0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sched.md
Name: pipe_hazard_sched

Overview:
- Central issue scheduler for the 5-stage pipeline. Sits beside the ID stage and decides each cycle whether the instruction in ID issues to EX, is held (stall), or is squashed (branch flush).
- Replaces pairwise EX/MEM address comparison with a per-register countdown scoreboard.
- Adds a run/drain/done FSM so the testbench can start the core and halt it cleanly once all in-flight writes have retired.
- Keeps saturating performance counters.

Parameters:
- WB_LAT, 3, stall cycles a dependent instruction immediately following its producer must wait (1..3; counter width 2 bits).
- CNT_W, 32, width of each performance counter.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_start  input  1  pulse: leave IDLE/DONE and run.
- in_halt  input  1  pulse: stop issuing and drain.
- in_rs_addr  input  5  rs field of the ID instruction.
- in_rt_addr  input  5  rt field of the ID instruction.
- in_rs_rena  input  1  ID instruction reads rs.
- in_rt_rena  input  1  ID instruction reads rt.
- in_rd_addr  input  5  destination of the ID instruction.
- in_rd_wena  input  1  ID instruction writes rd.
- in_branch  input  1  ID resolved a taken branch or jump.
- out_stall  output  1  ID held this cycle (not issuing).
- out_pc_wena  output  1  PC register update enable.
- out_if_id_wena  output  1  IF/ID latch enable.
- out_if_flush  output  1  squash the IF/ID latch at the next edge.
- out_id_bubble  output  1  load a NOP into ID/EX at the next edge.
- out_busy  output  1  any scoreboard entry nonzero.
- out_done  output  1  FSM in DONE.
- out_state  output  2  0=IDLE, 1=RUN, 2=DRAIN, 3=DONE.
- out_stall_count  output  CNT_W  hazard-stall cycles.
- out_flush_count  output  CNT_W  branch flushes.
- out_issue_count  output  CNT_W  issued instructions.

Behaviour:
- Reset values: state=IDLE, all 32 scoreboard counters=0, all perf counters=0.
- Derived outputs after reset: out_stall=1, out_pc_wena=0, out_if_id_wena=0, out_if_flush=0, out_id_bubble=1, out_busy=0, out_done=0.
- Hazard (combinational): (in_rs_rena && sb[rs]!=0) || (in_rt_rena && sb[rt]!=0). Register 0 never hazards.
- Issue (combinational): state==RUN && !in_halt && !hazard.
- Derived outputs:
  - out_stall = !issue
  - out_pc_wena = out_if_id_wena = issue
  - out_id_bubble = !issue
  - out_if_flush = issue && in_branch. A branch seen while stalled is ignored, because its operands are stale; it is re-evaluated when it issues.
- Scoreboard update each edge:
  - Every nonzero entry decrements by 1.
  - Then, if issue && in_rd_wena && rd!=0, sb[rd] is loaded with WB_LAT. The load overrides the decrement for the same entry, including WAW reload of an already-pending rd.
- Timing: producer issues in cycle t. A consumer of the same register sits in ID and stalls in cycles t+1..t+WB_LAT, then issues in cycle t+WB_LAT+1.
- FSM transitions (evaluated at the edge):
  - IDLE: in_start -> RUN; in_halt ignored.
  - RUN: in_halt -> DRAIN (halt beats a simultaneous start; no issue in the halt cycle); in_start ignored.
  - DRAIN: no issue; when out_busy==0 -> DONE. Evaluated on the pre-decrement scoreboard, so DONE is entered one edge after the last entry reaches 0.
  - DONE: in_start -> RUN; in_halt ignored.
- Perf counters (all saturate at all-ones):
  - stall_count increments when state==RUN && !in_halt && hazard.
  - flush_count increments when out_if_flush.
  - issue_count increments when issue.
- Reset mid-operation (any state, including pending scoreboard entries): everything returns to reset values at that edge; no pending write survives.
- All outputs except counters and state are combinational from the registered state and current inputs; no input-to-output latency beyond that.

Test Plan:
- Reset then in_start -> out_state=1; independent stream (rd=1..5, no reads of pending regs) -> 5 consecutive issues, issue_count=5, stall_count=0.
- Producer rd=8, next instruction reads rs=8 -> out_stall=1 for exactly 3 cycles, issue on 4th, stall_count=3. Repeat with WB_LAT=1 -> 1 stall cycle.
- Producer writes rd=0, then a reader of r0 -> no stall; sb never set.
- Taken branch with no hazard -> out_if_flush=1 for one cycle, flush_count=1. Branch held by a hazard for 2 cycles -> out_if_flush=0 during stall, =1 on the issue cycle only.
- Issue rd=9 then in_halt next cycle -> state 2 for 3 cycles, then state 3, out_done=1, out_busy=0. Simultaneous in_start+in_halt in RUN -> DRAIN.
- Assert in_rst while sb[9]=2 in DRAIN -> next cycle state=0, out_busy=0, all counters 0. Force issue_count to all-ones -> further issues leave it unchanged.
